ifetch_issue_unit: RTL and testbench

- Instruction fetch and issue stage of the 16-bit pipelined processor.
- Generates the PC stream, requests words from instruction memory, and buffers returned words in a small prefetch FIFO.
- Presents each instruction with its 4-bit opcode to the decode/control stage over a valid/ready handshake.
- Handles branch/jump redirects; stops fetching once a STOP instruction is issued.

---
 rtl/ifetch_issue_unit.sv | 163 ++++++++++++++++
 tb/tb_ifetch_issue_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_issue_unit
// Brief    : PC generation, instruction-memory requests, prefetch FIFO and
//            valid/ready issue toward decode, with redirect and STOP halt.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_issue_unit #(
    parameter int                  ADDR_W   = 8,
    parameter int                  INST_W   = 16,
    parameter int                  OP_WIDTH = 4,
    parameter int                  DEPTH    = 2,
    parameter logic [OP_WIDTH-1:0] STOP_OP  = 4'b0111
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   start_pc_i,
    output logic                imem_req_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    input  logic                imem_rvalid_i,
    input  logic [INST_W-1:0]   imem_rdata_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [INST_W-1:0]   inst_o,
    output logic [OP_WIDTH-1:0] opcode_o,
    output logic [ADDR_W-1:0]   inst_pc_o,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    output logic                halted_o
);
    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_req_pc;
    logic                 r_inflight;
    logic                 r_kill;
    logic                 r_halted;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [INST_W-1:0]    r_mem_inst [DEPTH];
    logic [ADDR_W-1:0]    r_mem_pc   [DEPTH];

    logic                 w_fetching;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_req;
    logic                 w_push;
    logic                 w_push_stop;
    logic                 w_stop_pop;
    logic [c_CNT_W:0]     w_used;
    logic [INST_W-1:0]    w_head_inst;
    logic [ADDR_W-1:0]    w_head_pc;

    assign w_fetching  = (r_state == S_FETCH);
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && inst_ready_i;
    assign w_head_inst = r_mem_inst[r_rd_ptr];
    assign w_head_pc   = r_mem_pc[r_rd_ptr];

    // Credit counts the slot freed by this cycle's pop so a 2-deep FIFO
    // still sustains one instruction per cycle.
    assign w_used = {1'b0, r_count}
                  - {{c_CNT_W{1'b0}}, w_pop}
                  + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_req  = w_fetching && !redirect_i && (w_used < c_DEPTH);

    assign w_push      = imem_rvalid_i && r_inflight && !r_kill && w_fetching && !redirect_i;
    assign w_push_stop = w_push && (imem_rdata_i[INST_W-1 -: OP_WIDTH] == STOP_OP);
    assign w_stop_pop  = w_pop && (r_state == S_DRAIN)
                      && (w_head_inst[INST_W-1 -: OP_WIDTH] == STOP_OP);

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_pc;
    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? w_head_inst : '0;
    assign opcode_o     = inst_o[INST_W-1 -: OP_WIDTH];
    assign inst_pc_o    = w_valid ? w_head_pc : '0;
    assign halted_o     = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
            r_halted   <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_req;
            r_kill     <= 1'b0;
            if (w_req) begin
                r_pc     <= r_pc + ADDR_W'(1);
                r_req_pc <= r_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + {{(c_CNT_W-1){1'b0}}, w_push}
                               - {{(c_CNT_W-1){1'b0}}, w_pop};

            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start_i) begin
                        r_pc       <= start_pc_i;
                        r_rd_ptr   <= '0;
                        r_wr_ptr   <= '0;
                        r_count    <= '0;
                        r_inflight <= 1'b0;
                        r_halted   <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH, S_DRAIN: begin
                    if (redirect_i) begin
                        // Any handshake this cycle has already popped; flush the rest.
                        r_pc     <= redirect_pc_i;
                        r_kill   <= r_inflight;
                        r_rd_ptr <= '0;
                        r_wr_ptr <= '0;
                        r_count  <= '0;
                        r_state  <= S_FETCH;
                    end else if (w_push_stop) begin
                        r_state <= S_DRAIN;
                    end else if (w_stop_pop) begin
                        r_rd_ptr <= '0;
                        r_wr_ptr <= '0;
                        r_count  <= '0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata_i;
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_issue_unit
// Brief    : Self-checking bench: directed table, corner sequences and random
//            traffic compared against a queue-based fetch/issue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_issue_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  start_pc_i;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        imem_rvalid_i;
    logic [15:0] imem_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [15:0] inst_o;
    logic [3:0]  opcode_o;
    logic [7:0]  inst_pc_o;
    logic        redirect_i;
    logic [7:0]  redirect_pc_i;
    logic        halted_o;

    always #5 clk = ~clk;

    ifetch_issue_unit #(
        .ADDR_W(8), .INST_W(16), .OP_WIDTH(4), .DEPTH(DEPTH), .STOP_OP(4'b0111)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_i(start_i), .start_pc_i(start_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .opcode_o(opcode_o), .inst_pc_o(inst_pc_o),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .halted_o(halted_o)
    );

    typedef struct { logic [15:0] inst; logic [7:0] pc; } entry_t;
    typedef struct {
        bit start; logic [7:0] spc; bit ready;
        bit exp_req; logic [7:0] exp_addr; bit exp_valid; logic [7:0] exp_pc; logic [3:0] exp_op;
    } vec_t;

    // Model modes: 0 idle, 1 fetching, 2 draining after STOP, 3 halted
    entry_t      m_q[$];
    int          m_mode;
    bit          m_pend, m_kill, m_halted;
    logic [7:0]  m_paddr, m_pc;

    logic [15:0] mem [256];
    logic [7:0]  dlv_pc[$];
    logic [3:0]  dlv_op[$];
    bit          req_q;
    logic [7:0]  addr_q;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dlv_at(input int i);
        if (i < dlv_pc.size()) return dlv_pc[i];
        return 8'hxx;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_mode = 0; m_pend = 0; m_kill = 0; m_halted = 0; m_paddr = 0; m_pc = 0;
    endtask

    function automatic bit model_req(input bit rdy, input bit rd);
        int used;
        used = m_q.size() - int'((m_q.size() != 0) && rdy) + int'(m_pend);
        return (m_mode == 1) && !rd && (used < DEPTH);
    endfunction

    task automatic model_step(input bit pop, input bit req);
        entry_t popped, e;
        bit stop_pop;
        stop_pop = 0;
        if (m_mode == 0 || m_mode == 3) begin
            if (start_i) begin
                m_pc = start_pc_i; m_q.delete(); m_halted = 0; m_mode = 1;
            end
            m_pend = 0; m_kill = 0;
        end else begin
            if (pop) begin
                popped   = m_q.pop_front();
                stop_pop = (m_mode == 2) && (popped.inst[15:12] == 4'h7);
            end
            if (redirect_i) begin
                m_q.delete(); m_pc = redirect_pc_i; m_kill = m_pend; m_pend = 0; m_mode = 1;
            end else begin
                if (m_pend && !m_kill && m_mode == 1) begin
                    e.inst = mem[m_paddr]; e.pc = m_paddr;
                    m_q.push_back(e);
                    if (e.inst[15:12] == 4'h7) m_mode = 2;
                end
                m_kill = 0;
                if (stop_pop) begin
                    m_mode = 3; m_halted = 1; m_q.delete();
                end
                if (req) begin
                    m_pend = 1; m_paddr = m_pc; m_pc = m_pc + 8'd1;
                end else begin
                    m_pend = 0;
                end
            end
        end
    endtask

    task automatic settle(input bit st, input logic [7:0] spc, input bit rdy,
                          input bit rd, input logic [7:0] rpc);
        start_i = st; start_pc_i = spc; inst_ready_i = rdy;
        redirect_i = rd; redirect_pc_i = rpc;
        @(negedge clk);
    endtask

    // Compare this cycle against the model, advance it, then act as the memory.
    task automatic finish_cycle();
        bit exp_valid, exp_req;
        entry_t head;
        head.inst = 16'h0; head.pc = 8'h0;
        exp_valid = (m_q.size() != 0);
        if (exp_valid) head = m_q[0];
        exp_req = model_req(inst_ready_i, redirect_i);
        check("imem_req",   imem_req_o,   exp_req);
        check("imem_addr",  imem_addr_o,  m_pc);
        check("inst_valid", inst_valid_o, exp_valid);
        check("inst",       inst_o,       head.inst);
        check("opcode",     opcode_o,     head.inst[15:12]);
        check("inst_pc",    inst_pc_o,    head.pc);
        check("halted",     halted_o,     m_halted);
        if (inst_valid_o && inst_ready_i) begin
            dlv_pc.push_back(inst_pc_o);
            dlv_op.push_back(opcode_o);
        end
        model_step(exp_valid && inst_ready_i, exp_req);
        req_q = imem_req_o; addr_q = imem_addr_o;
        @(posedge clk);
        #1;
        imem_rvalid_i = req_q;
        imem_rdata_i  = req_q ? mem[addr_q] : 16'($urandom);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int k = 0; k < n; k++) begin
            settle(1'b0, 8'h00, rdy, 1'b0, 8'h00);
            finish_cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   n0, bp_start;
        bit   done, hit;

        rst_n = 1'b0; start_i = 0; start_pc_i = 0; inst_ready_i = 0;
        redirect_i = 0; redirect_pc_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        for (int a = 0; a < 256; a++) mem[a] = {4'b0010, 4'h0, 8'(a)};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Launch from 0x10: one request cycle after start, data visible after the response.
        vt[0] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0};
        vt[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 4'h0};
        vt[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 4'h0};
        vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b1, 8'h10, 4'h2};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h13, 1'b1, 8'h11, 4'h2};
        vt[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h14, 1'b1, 8'h12, 4'h2};
        for (int i = 0; i < 6; i++) begin
            settle(vt[i].start, vt[i].spc, vt[i].ready, 1'b0, 8'h00);
            check($sformatf("tbl%0d_req", i),   imem_req_o,   vt[i].exp_req);
            check($sformatf("tbl%0d_addr", i),  imem_addr_o,  vt[i].exp_addr);
            check($sformatf("tbl%0d_valid", i), inst_valid_o, vt[i].exp_valid);
            check($sformatf("tbl%0d_pc", i),    inst_pc_o,    vt[i].exp_pc);
            check($sformatf("tbl%0d_op", i),    opcode_o,     vt[i].exp_op);
            check($sformatf("tbl%0d_halt", i),  halted_o,     1'b0);
            finish_cycle();
        end

        // Backpressure: five stalled cycles, requests stop with the FIFO full.
        bp_start = dlv_pc.size();
        for (int k = 0; k < 5; k++) begin
            settle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
            if (k == 4) begin
                check("bp_req_stopped", imem_req_o, 1'b0);
                check("bp_head_pc", inst_pc_o, 8'h13);
            end
            finish_cycle();
        end
        check("bp_no_delivery", dlv_pc.size() - bp_start, 0);
        run(4, 1'b1);
        check("bp_resume0", dlv_at(3), 8'h13);
        check("bp_resume1", dlv_at(4), 8'h14);
        for (int i = 0; i < dlv_pc.size(); i++)
            check($sformatf("seq_pc%0d", i), dlv_pc[i], 8'(8'h10 + i));

        // Redirect with one buffered entry and one response in flight.
        run(2, 1'b1);
        settle(1'b0, 8'h00, 1'b0, 1'b1, 8'h40);
        check("redir_valid_pre", inst_valid_o, 1'b1);
        check("redir_no_req", imem_req_o, 1'b0);
        finish_cycle();
        n0 = dlv_pc.size();
        for (int k = 0; k < 10 && dlv_pc.size() <= n0; k++) run(1, 1'b1);
        check("redir_first_pc", dlv_at(n0), 8'h40);

        // STOP at 0x13 ends the stream.
        mem[8'h13] = 16'h7000;
        settle(1'b0, 8'h00, 1'b1, 1'b1, 8'h10);
        finish_cycle();
        n0 = dlv_pc.size();
        done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            settle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
            if (halted_o) done = 1;
            finish_cycle();
        end
        check("stop_halted", done, 1'b1);
        check("stop_count", dlv_pc.size() - n0, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("stop_pc%0d", i), dlv_at(n0 + i), 8'(8'h10 + i));
        check("stop_last_op", (dlv_op.size() > n0 + 3) ? dlv_op[n0 + 3] : 4'hx, 4'h7);
        for (int k = 0; k < 4; k++) begin
            settle(1'b0, 8'h00, 1'b1, 1'b1, 8'h55);
            check("halt_no_req", imem_req_o, 1'b0);
            finish_cycle();
        end
        settle(1'b1, 8'h20, 1'b1, 1'b0, 8'h00);
        finish_cycle();
        n0 = dlv_pc.size();
        for (int k = 0; k < 10 && dlv_pc.size() <= n0; k++) run(1, 1'b1);
        check("relaunch_pc", dlv_at(n0), 8'h20);
        check("relaunch_halted", halted_o, 1'b0);

        // PC wrap from 0xFF.
        settle(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF);
        finish_cycle();
        n0 = dlv_pc.size();
        for (int k = 0; k < 10 && dlv_pc.size() < n0 + 2; k++) run(1, 1'b1);
        check("wrap_pc0", dlv_at(n0), 8'hFF);
        check("wrap_pc1", dlv_at(n0 + 1), 8'h00);

        // Redirect arriving with the STOP response wins.
        mem[8'h63] = 16'h7123;
        settle(1'b0, 8'h00, 1'b1, 1'b1, 8'h60);
        finish_cycle();
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            done = imem_rvalid_i && (imem_rdata_i[15:12] == 4'h7);
            settle(1'b0, 8'h00, 1'b1, done, 8'h80);
            if (done) hit = 1;
            finish_cycle();
        end
        check("coinc_hit", hit, 1'b1);
        n0 = dlv_pc.size();
        run(6, 1'b1);
        check("coinc_first_pc", dlv_at(n0), 8'h80);
        check("coinc_not_halted", halted_o, 1'b0);

        // Asynchronous reset mid-stream.
        run(3, 1'b0);
        check("arst_valid_pre", inst_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",   imem_req_o,   1'b0);
        check("arst_addr",  imem_addr_o,  8'h00);
        check("arst_valid", inst_valid_o, 1'b0);
        check("arst_inst",  inst_o,       16'h0);
        check("arst_op",    opcode_o,     4'h0);
        check("arst_pc",    inst_pc_o,    8'h00);
        check("arst_halt",  halted_o,     1'b0);
        model_reset();
        imem_rvalid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
            check("post_rst_no_req", imem_req_o, 1'b0);
            finish_cycle();
        end

        // Random traffic against the model.
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        for (int k = 0; k < 3000; k++) begin
            bit st;
            st = ($urandom_range(0, 19) == 0) || ((m_mode == 0 || m_mode == 3) && $urandom_range(0, 2) == 0);
            settle(st, 8'($urandom), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 24) == 0, 8'($urandom));
            finish_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
